// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver
//   Multiplexed seven-segment display driver. It shows a DIGITS-digit value
//   as hex or decimal. Decimal uses a sequential double-dabble converter that
//   handles one bit per cycle. It supports per-digit decimal points,
//   leading-zero blanking and decimal overflow indication (all dashes).
//   A load is captured into shadow registers. The visible digit, blank and
//   dp registers change in a single COMMIT cycle, so a partially converted
//   value is never shown.
// Ports
//   clk       system clock
//   reset     asynchronous active-high reset
//   load      capture request, honoured only while ready=1
//   value     unsigned value to display (BIN_W bits)
//   mode_dec  1 = decimal, 0 = hex
//   blank_lz  1 = blank leading zero digits
//   dp_mask   bit i requests the decimal point of digit i
//   ready     1 = idle, a new load is accepted
//   seg       {g,f,e,d,c,b,a}, active-low
//   an        digit enables, active-low, an[0] = rightmost digit
//   dp        decimal point, active-low
module ssd_scan_driver #(
  parameter  int DIGITS      = 4,
  parameter  int REFRESH_DIV = 100000,
  localparam int BIN_W       = 4 * DIGITS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [BIN_W-1:0]  value,
  input  logic              mode_dec,
  input  logic              blank_lz,
  input  logic [DIGITS-1:0] dp_mask,
  output logic              ready,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              dp
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int BIT_W = $clog2(BIN_W);
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] DEC_MAX = pow10(DIGITS) - 64'd1;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  // Add-3 correction applied to every BCD nibble before each shift.
  function automatic logic [BIN_W-1:0] dd_adj(input logic [BIN_W-1:0] b);
    logic [BIN_W-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++)
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    return r;
  endfunction

  // Digits above the most significant nonzero one are blanked; digit 0 never is.
  function automatic logic [DIGITS-1:0] lz_mask(input logic [BIN_W-1:0] d);
    logic [DIGITS-1:0] r;
    logic              seen;
    r    = '0;
    seen = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (d[4*i +: 4] != 4'd0) seen = 1'b1;
      r[i] = ~seen;
    end
    return r;
  endfunction

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t            state;
  logic [BIT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  ref_cnt;
  logic [IDX_W-1:0]  idx;

  // shadow snapshot and converter working registers (no reset needed)
  logic [BIN_W-1:0]  sh_bin;
  logic [BIN_W-1:0]  bcd;
  logic              sh_dec;
  logic              sh_blz;
  logic              sh_ovf;
  logic [DIGITS-1:0] sh_dp;

  // committed display registers
  logic [BIN_W-1:0]  disp_dig;
  logic [DIGITS-1:0] disp_blank;
  logic [DIGITS-1:0] disp_dp;
  logic              disp_ovf;

  logic [BIN_W-1:0]  commit_dig;
  logic              commit_ovf;
  logic [3:0]        cur_dig;
  logic              cur_blank;
  logic              cur_dp;
  logic [DIGITS-1:0] an_next;
  logic [6:0]        seg_next;

  // Hex loads bypass the converter, so sh_bin still holds the snapshot.
  assign commit_dig = sh_dec ? bcd : sh_bin;
  assign commit_ovf = sh_dec & sh_ovf;

  always_ff @(posedge clk) begin
    if (state == IDLE && load) begin
      sh_bin <= value;
      sh_dec <= mode_dec;
      sh_blz <= blank_lz;
      sh_dp  <= dp_mask;
      sh_ovf <= ({{(64-BIN_W){1'b0}}, value} > DEC_MAX);
      bcd    <= '0;
    end else if (state == CONV) begin
      bcd    <= {dd_adj(bcd)[BIN_W-2:0], sh_bin[BIN_W-1]};
      sh_bin <= sh_bin << 1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ready      <= 1'b1;
      bit_cnt    <= '0;
      disp_dig   <= '0;
      disp_blank <= '0;
      disp_dp    <= '0;
      disp_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            ready   <= 1'b0;
            bit_cnt <= '0;
            state   <= mode_dec ? CONV : COMMIT;
          end
        end
        CONV: begin
          if (bit_cnt == BIT_W'(BIN_W - 1)) state <= COMMIT;
          else bit_cnt <= bit_cnt + BIT_W'(1);
        end
        COMMIT: begin
          disp_dig   <= commit_dig;
          disp_ovf   <= commit_ovf;
          disp_blank <= (sh_blz && !commit_ovf) ? lz_mask(commit_dig) : '0;
          disp_dp    <= sh_dp;
          ready      <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    cur_dig   = 4'd0;
    cur_blank = 1'b0;
    cur_dp    = 1'b0;
    an_next   = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_dig    = disp_dig[4*i +: 4];
        cur_blank  = disp_blank[i];
        cur_dp     = disp_dp[i];
        an_next[i] = 1'b0;
      end
    end
    seg_next = disp_ovf ? SEG_DASH : (cur_blank ? SEG_OFF : glyph(cur_dig));
  end

  // seg/an/dp are all registered from the same index, so they switch together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_cnt <= '0;
      idx     <= '0;
      seg     <= SEG_OFF;
      an      <= '1;
      dp      <= 1'b1;
    end else begin
      seg <= seg_next;
      an  <= an_next;
      dp  <= ~cur_dp;
      if (ref_cnt == CNT_W'(REFRESH_DIV - 1)) begin
        ref_cnt <= '0;
        idx     <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
      end else begin
        ref_cnt <= ref_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
module tb_ssd_scan_driver;

  localparam int DIGITS = 4;
  localparam int RDIV   = 4;
  localparam int BIN_W  = 4 * DIGITS;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              load = 1'b0;
  logic [BIN_W-1:0]  value = '0;
  logic              mode_dec = 1'b0;
  logic              blank_lz = 1'b0;
  logic [DIGITS-1:0] dp_mask = '0;
  logic              ready;
  logic [6:0]        seg;
  logic [DIGITS-1:0] an;
  logic              dp;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  // reference display state (what should currently be committed)
  int unsigned       m_val = 0;
  bit                m_dec = 0;
  bit                m_blz = 0;
  logic [DIGITS-1:0] m_dp  = '0;

  logic [6:0] glyph_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  ssd_scan_driver #(.DIGITS(DIGITS), .REFRESH_DIV(RDIV)) dut (
    .clk(clk), .reset(reset), .load(load), .value(value), .mode_dec(mode_dec),
    .blank_lz(blank_lz), .dp_mask(dp_mask), .ready(ready), .seg(seg), .an(an), .dp(dp)
  );

  always #5 clk = ~clk;

  // clock edges seen since reset was last released
  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;

  function automatic int unsigned upow(input int unsigned b, input int n);
    int unsigned r = 1;
    for (int k = 0; k < n; k++) r = r * b;
    return r;
  endfunction

  function automatic logic [6:0] exp_seg(input int i);
    int unsigned base = m_dec ? 10 : 16;
    int unsigned pw   = upow(base, i);
    if (m_dec && m_val > upow(10, DIGITS) - 1) return 7'b0111111;
    if (m_blz && i > 0 && (m_val / pw) == 0) return 7'h7F;
    return glyph_tab[(m_val / pw) % base];
  endfunction

  task automatic check(input bit exp_ready);
    int i;
    logic [DIGITS-1:0] ea;
    logic [6:0] es;
    logic ed;
    if (cyc == 0) begin
      ea = '1; es = 7'h7F; ed = 1'b1;
    end else begin
      i  = ((cyc - 1) / RDIV) % DIGITS;
      ea = ~(DIGITS'(1) << i);
      es = exp_seg(i);
      ed = ~m_dp[i];
    end
    tests++;
    assert (an === ea) else begin
      failed++; $error("FAIL an observed=%h expected=%h t=%0t", an, ea, $time);
    end
    tests++;
    assert (seg === es) else begin
      failed++; $error("FAIL seg observed=%b expected=%b an=%h t=%0t", seg, es, an, $time);
    end
    tests++;
    assert (dp === ed) else begin
      failed++; $error("FAIL dp observed=%b expected=%b an=%h t=%0t", dp, ed, an, $time);
    end
    tests++;
    assert (ready === exp_ready) else begin
      failed++; $error("FAIL ready observed=%b expected=%b t=%0t", ready, exp_ready, $time);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); @(negedge clk);
      check(1'b1);
    end
  endtask

  // Called at a negedge with ready=1. A second load (v2) may be attempted
  // during the conversion; it must be ignored.
  task automatic do_load(input logic [BIN_W-1:0] v, input bit dec, input bit blz,
                         input logic [DIGITS-1:0] dpm, input bit interfere,
                         input logic [BIN_W-1:0] v2);
    int lat = dec ? BIN_W + 2 : 2;
    load = 1'b1; value = v; mode_dec = dec; blank_lz = blz; dp_mask = dpm;
    @(posedge clk); @(negedge clk);
    load = 1'b0;
    check(1'b0);
    for (int k = 1; k <= lat; k++) begin
      if (interfere && k == 5) begin
        load = 1'b1; value = v2; mode_dec = 1'b1; blank_lz = ~blz; dp_mask = ~dpm;
      end
      @(posedge clk); @(negedge clk);
      load = 1'b0;
      if (k == lat) begin
        m_val = v; m_dec = dec; m_blz = blz; m_dp = dpm;
      end
      check(k >= lat - 1);
    end
  endtask

  initial begin
    logic [BIN_W-1:0] rv;
    bit rdec, rblz, rint;
    // reset held
    repeat (3) begin @(negedge clk); check(1'b1); end
    reset = 1'b0;
    idle(20);

    // hex 1A2F with dp on digit 2
    do_load(16'h1A2F, 1'b0, 1'b0, 4'b0100, 1'b0, '0);
    idle(16);
    // decimal 1234
    do_load(16'd1234, 1'b1, 1'b0, 4'b0000, 1'b0, '0);
    idle(16);
    // decimal overflow, blanking requested but suppressed
    do_load(16'd10000, 1'b1, 1'b1, 4'b0001, 1'b0, '0);
    idle(16);
    // decimal 5 with leading-zero blanking
    do_load(16'd5, 1'b1, 1'b1, 4'b1000, 1'b0, '0);
    idle(16);
    // zero with blanking keeps digit 0
    do_load(16'd0, 1'b0, 1'b1, 4'b0000, 1'b0, '0);
    idle(16);
    // second load during conversion is ignored
    do_load(16'd1234, 1'b1, 1'b0, 4'b0010, 1'b1, 16'd42);
    idle(16);
    // upper bound of decimal range
    do_load(16'd9999, 1'b1, 1'b1, 4'b0000, 1'b0, '0);
    idle(16);

    // reset during conversion
    load = 1'b1; value = 16'd4321; mode_dec = 1'b1; blank_lz = 1'b0; dp_mask = 4'b1111;
    @(posedge clk); @(negedge clk);
    load = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    m_val = 0; m_dec = 0; m_blz = 0; m_dp = '0;
    check(1'b1);
    @(negedge clk);
    check(1'b1);
    reset = 1'b0;
    idle(24);

    // randomized loads
    for (int n = 0; n < 30; n++) begin
      rv   = BIN_W'($urandom) >> $urandom_range(0, BIN_W - 1);
      rdec = 1'($urandom);
      rblz = 1'($urandom);
      rint = rdec && 1'($urandom);
      do_load(rv, rdec, rblz, DIGITS'($urandom), rint, BIN_W'($urandom));
      idle($urandom_range(0, 16));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
